// File: rtl/iot_event_serializer.sv
// iot_event_serializer
//
// Turns online/offline level changes on N_DEV devices into a stream of single-cycle
// change events (at most one per cycle) for the downstream active-device counter.
// Each device has a one-deep pending slot. Simultaneous transitions wait in their slots
// and are issued round-robin. A transition that is reversed before it is issued
// cancels out and produces no event.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   dev_on       per-device level (1 = online), synchronous to clk
//   change       registered one-cycle event strobe
//   on_off       event direction (1 = came online); 0 when no event
//   dev_id       device index of the presented event; holds when idle
//   pending_cnt  number of devices with a queued, not-yet-issued event
//
// Optional feature: define IOT_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable cycles
// of a new level before it is accepted as a transition.

module iot_event_serializer #(
    parameter int unsigned N_DEV = 8,
    parameter int unsigned ID_W  = $clog2(N_DEV),
    parameter int unsigned CNT_W = $clog2(N_DEV + 1)
`ifdef IOT_DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CYCLES = 3
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_on,
    output logic             change,
    output logic             on_off,
    output logic [ID_W-1:0]  dev_id,
    output logic [CNT_W-1:0] pending_cnt
);

    logic [N_DEV-1:0] dev_q, dev_d;
    logic [N_DEV-1:0] pending_q, pending_d;
    logic [N_DEV-1:0] pend_dir_q, pend_dir_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             change_q;
    logic             on_off_q;
    logic [ID_W-1:0]  dev_id_q;
    logic [CNT_W-1:0] pending_cnt_q, pending_cnt_d;

    logic [N_DEV-1:0] edge_det;
    logic             found;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  idx;

    // ------------------------------------------------------------------
    // Transition detection
    // ------------------------------------------------------------------
`ifdef IOT_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_cnt_q [N_DEV];
    logic [DB_W-1:0] db_cnt_d [N_DEV];

    // The counter only ever reaches DEBOUNCE_CYCLES on the cycle the edge is taken,
    // and clears right away, so it never needs an explicit saturation guard.
    always_comb begin
        for (int i = 0; i < N_DEV; i++) begin
            edge_det[i] = 1'b0;
            db_cnt_d[i] = db_cnt_q[i];
            if (dev_on[i] == dev_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES)) begin
                edge_det[i] = 1'b1;
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_DEV; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_DEV; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end
`else
    assign edge_det = dev_on ^ dev_q;
`endif

    // An edge always means dev_on differs from dev_q, so flipping equals copying.
    assign dev_d = dev_q ^ edge_det;

    // ------------------------------------------------------------------
    // Round-robin arbiter over the registered pending vector
    // ------------------------------------------------------------------
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int unsigned k = 0; k < N_DEV; k++) begin
            idx = ID_W'((32'(rr_ptr_q) + k) % N_DEV);
            if (!found && pending_q[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue update: service clear first, then new edges
    // ------------------------------------------------------------------
    always_comb begin
        pending_d  = pending_q;
        pend_dir_d = pend_dir_q;
        if (found) begin
            pending_d[grant] = 1'b0;
        end
        for (int i = 0; i < N_DEV; i++) begin
            if (edge_det[i]) begin
                if (pending_d[i]) begin
                    // Still-queued event reversed before issue: net zero, drop both.
                    pending_d[i] = 1'b0;
                end else begin
                    pending_d[i]  = 1'b1;
                    pend_dir_d[i] = dev_on[i];
                end
            end
        end

        pending_cnt_d = '0;
        for (int i = 0; i < N_DEV; i++) begin
            pending_cnt_d = pending_cnt_d + CNT_W'(pending_d[i]);
        end

        rr_ptr_d = rr_ptr_q;
        if (found) begin
            rr_ptr_d = (grant == ID_W'(N_DEV - 1)) ? '0 : grant + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            dev_q         <= '0;
            pending_q     <= '0;
            pend_dir_q    <= '0;
            rr_ptr_q      <= '0;
            change_q      <= 1'b0;
            on_off_q      <= 1'b0;
            dev_id_q      <= '0;
            pending_cnt_q <= '0;
        end else begin
            dev_q         <= dev_d;
            pending_q     <= pending_d;
            pend_dir_q    <= pend_dir_d;
            rr_ptr_q      <= rr_ptr_d;
            change_q      <= found;
            on_off_q      <= found & pend_dir_q[grant];
            if (found) begin
                dev_id_q <= grant;
            end
            pending_cnt_q <= pending_cnt_d;
        end
    end

    assign change      = change_q;
    assign on_off      = on_off_q;
    assign dev_id      = dev_id_q;
    assign pending_cnt = pending_cnt_q;

endmodule

// File: tb/tb_iot_event_serializer.sv
// Bench for iot_event_serializer with N_DEV=4, debounce disabled.
//
// Reference model: each device keeps the level last accepted from dev_on (m_acc) and
// the level last reported downstream (m_rep). A device has an event outstanding exactly
// when those differ, and the event direction is the accepted level.

module tb_iot_event_serializer;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] dev_on = 4'b0000;
    logic       change;
    logic       on_off;
    logic [1:0] dev_id;
    logic [2:0] pending_cnt;

    iot_event_serializer #(
        .N_DEV(N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dev_on     (dev_on),
        .change     (change),
        .on_off     (on_off),
        .dev_id     (dev_id),
        .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0] m_rep = '0;
    logic [3:0] m_acc = '0;
    int         m_ptr = 0;
    logic       m_change = 1'b0;
    logic       m_on_off = 1'b0;
    logic [1:0] m_id = '0;
    int         m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge.
    function automatic void model_tick(input logic [3:0] on, input logic r);
        bit found;
        int g;
        if (!r) begin
            m_rep    = '0;
            m_acc    = '0;
            m_ptr    = 0;
            m_change = 1'b0;
            m_on_off = 1'b0;
            m_id     = '0;
            m_cnt    = 0;
            return;
        end
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (!found && (m_rep[i] != m_acc[i])) begin
                found = 1'b1;
                g     = i;
            end
        end
        if (found) begin
            m_change = 1'b1;
            m_on_off = m_acc[g];
            m_id     = 2'(g);
            m_rep[g] = m_acc[g];
            m_ptr    = (g + 1) % N;
        end else begin
            m_change = 1'b0;
            m_on_off = 1'b0;
        end
        m_acc = on;
        m_cnt = $countones(m_rep ^ m_acc);
    endfunction

    task automatic step(input logic [3:0] on, input logic r);
        dev_on = on;
        rst    = r;
        @(posedge clk);
        model_tick(on, r);
        #1;
        chk("model_change", 32'(change), 32'(m_change));
        chk("model_on_off", 32'(on_off), 32'(m_on_off));
        chk("model_dev_id", 32'(dev_id), 32'(m_id));
        chk("model_pending_cnt", 32'(pending_cnt), 32'(m_cnt));
    endtask

    // Directed expectations taken straight from the required behaviour.
    task automatic want(input string tag, input logic ch, input logic oo, input logic [1:0] id,
                        input logic [2:0] cnt);
        chk({tag, "_change"}, 32'(change), 32'(ch));
        chk({tag, "_on_off"}, 32'(on_off), 32'(oo));
        if (ch) chk({tag, "_dev_id"}, 32'(dev_id), 32'(id));
        chk({tag, "_pending_cnt"}, 32'(pending_cnt), 32'(cnt));
    endtask

    task automatic drain(input int cycles);
        for (int c = 0; c < cycles; c++) step(dev_on, 1'b1);
    endtask

    initial begin
        // 1. Reset and reconnect
        step(4'b1111, 1'b0);
        want("t1_rst_a", 1'b0, 1'b0, 2'd0, 3'd0);
        chk("t1_rst_dev_id", 32'(dev_id), 32'd0);
        step(4'b1111, 1'b0);
        want("t1_rst_b", 1'b0, 1'b0, 2'd0, 3'd0);
        step(4'b1111, 1'b1);
        want("t1_rel", 1'b0, 1'b0, 2'd0, 3'd4);
        step(4'b1111, 1'b1);
        want("t1_ev0", 1'b1, 1'b1, 2'd0, 3'd3);
        step(4'b1111, 1'b1);
        want("t1_ev1", 1'b1, 1'b1, 2'd1, 3'd2);
        step(4'b1111, 1'b1);
        want("t1_ev2", 1'b1, 1'b1, 2'd2, 3'd1);
        step(4'b1111, 1'b1);
        want("t1_ev3", 1'b1, 1'b1, 2'd3, 3'd0);
        step(4'b1111, 1'b1);
        want("t1_idle", 1'b0, 1'b0, 2'd0, 3'd0);

        // Back to all offline (four off events), rr pointer returns to 0
        step(4'b0000, 1'b1);
        drain(5);

        // 2. Single transition
        step(4'b0100, 1'b1);
        want("t2_up_e0", 1'b0, 1'b0, 2'd0, 3'd1);
        step(4'b0100, 1'b1);
        want("t2_up_ev", 1'b1, 1'b1, 2'd2, 3'd0);
        step(4'b0000, 1'b1);
        want("t2_dn_e0", 1'b0, 1'b0, 2'd0, 3'd1);
        step(4'b0000, 1'b1);
        want("t2_dn_ev", 1'b1, 1'b0, 2'd2, 3'd0);

        // 5. Round-robin: pointer now sits at 3
        step(4'b1001, 1'b1);
        want("t5_e0", 1'b0, 1'b0, 2'd0, 3'd2);
        step(4'b1001, 1'b1);
        want("t5_first", 1'b1, 1'b1, 2'd3, 3'd1);
        step(4'b1001, 1'b1);
        want("t5_second", 1'b1, 1'b1, 2'd0, 3'd0);

        // Drop device 0 then device 3 so the pointer ends at 0
        step(4'b1000, 1'b1);
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // 3. Simultaneous edges
        step(4'b1011, 1'b1);
        want("t3_e0", 1'b0, 1'b0, 2'd0, 3'd3);
        step(4'b1011, 1'b1);
        want("t3_ev0", 1'b1, 1'b1, 2'd0, 3'd2);
        step(4'b1011, 1'b1);
        want("t3_ev1", 1'b1, 1'b1, 2'd1, 3'd1);
        step(4'b1011, 1'b1);
        want("t3_ev3", 1'b1, 1'b1, 2'd3, 3'd0);
        step(4'b1011, 1'b1);
        want("t3_idle", 1'b0, 1'b0, 2'd0, 3'd0);
        step(4'b0000, 1'b1);
        drain(4);

        // 4. Glitch cancel on device 3
        step(4'b1111, 1'b1);
        want("t4_e0", 1'b0, 1'b0, 2'd0, 3'd4);
        step(4'b0111, 1'b1);
        want("t4_ev0", 1'b1, 1'b1, 2'd0, 3'd2);
        step(4'b0111, 1'b1);
        want("t4_ev1", 1'b1, 1'b1, 2'd1, 3'd1);
        step(4'b0111, 1'b1);
        want("t4_ev2", 1'b1, 1'b1, 2'd2, 3'd0);
        step(4'b0111, 1'b1);
        want("t4_no_ev3_a", 1'b0, 1'b0, 2'd0, 3'd0);
        step(4'b0111, 1'b1);
        want("t4_no_ev3_b", 1'b0, 1'b0, 2'd0, 3'd0);
        step(4'b0000, 1'b1);
        drain(4);

        // 6. Reset mid-drain
        step(4'b0111, 1'b1);
        want("t6_e0", 1'b0, 1'b0, 2'd0, 3'd3);
        step(4'b0111, 1'b0);
        want("t6_rst", 1'b0, 1'b0, 2'd0, 3'd0);
        chk("t6_rst_dev_id", 32'(dev_id), 32'd0);
        step(4'b0111, 1'b1);
        want("t6_rel", 1'b0, 1'b0, 2'd0, 3'd3);
        step(4'b0111, 1'b1);
        want("t6_ev0", 1'b1, 1'b1, 2'd0, 3'd2);
        step(4'b0111, 1'b1);
        want("t6_ev1", 1'b1, 1'b1, 2'd1, 3'd1);
        step(4'b0111, 1'b1);
        want("t6_ev2", 1'b1, 1'b1, 2'd2, 3'd0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 39) != 0));
        end

        // Quiesce: everything outstanding must drain
        step(4'b0000, 1'b1);
        drain(6);
        chk("final_pending_cnt", 32'(pending_cnt), 32'd0);
        chk("final_change", 32'(change), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/iot_event_serializer.md
Name: iot_event_serializer

Overview:
- Upstream stage of the active IoT devices monitor counter.
- Watches the online/offline level of N_DEV devices and turns each level transition into a single change pulse with an on_off direction.
- Emits at most one event per cycle, which is exactly the form the counter consumes.
- Transitions on several devices in the same cycle are queued per device and served round-robin, so no transition is lost and no device is starved.

Parameters:
- N_DEV, 8, number of monitored devices (≥2).
- ID_W, $clog2(N_DEV), width of dev_id.
- CNT_W, $clog2(N_DEV+1), width of pending_cnt.
- DEBOUNCE_CYCLES, 3, stable-level cycles required (used only when DEBOUNCE_EN is defined).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  one clock; reset is synchronous and active-low (0 = reset, sampled on clk rising edge).
- dev_on  input  N_DEV  current level per device (1 = online); synchronous to clk.
- change  output  1  one-cycle pulse: an event is presented this cycle.
- on_off  output  1  event direction when change=1 (1 = came online, 0 = went offline).
- dev_id  output  ID_W  index of the device whose event is presented.
- pending_cnt  output  CNT_W  number of devices with a queued, not-yet-issued event.

Behaviour:
- State: dev_q[N_DEV] (last accepted level), pending[N_DEV], pend_dir[N_DEV], rr_ptr[ID_W], registered outputs.
- Reset (rst=0 at a rising edge):
  - dev_q, pending, pend_dir, rr_ptr, change, on_off, dev_id and pending_cnt all become 0.
  - Reset takes priority over every other update.
  - A device still online when reset is released produces an "on" event, so the downstream counter rebuilds its count.
- Edge detect: edge[i] = dev_on[i] ^ dev_q[i]. On each edge, dev_q[i] <= dev_on[i].
- Queue update per device, applied after the service clear of the same cycle:
  - edge and not pending: pending[i]<=1, pend_dir[i]<=dev_on[i].
  - edge and pending (always opposite direction): pending[i]<=0, net-zero glitch cancelled, no event issued.
  - If device i is being serviced in the same cycle as its new edge, the old event is issued and the new edge is queued (pending stays 1, pend_dir takes the new level).
- Arbiter, each cycle, from registered pending:
  - Select the first i with pending[i]=1, searching rr_ptr, rr_ptr+1, … with wrap at N_DEV-1 → 0.
  - If found: change<=1, on_off<=pend_dir[i], dev_id<=i, clear pending[i], rr_ptr<=(i+1) mod N_DEV.
  - If none: change<=0, on_off<=0, dev_id holds, rr_ptr holds.
- Latency: a level first sampled as changed at edge E0 sets pending at E0. The earliest change pulse is registered at E1 (one cycle).
- Throughput: one event per cycle. Back-to-back change pulses are legal. With K devices pending, the queue drains in K consecutive cycles if no new edges arrive.
- pending_cnt: registered popcount of the next-state pending vector, consistent with pending after each edge.
- No backpressure; the downstream stage accepts every cycle.

Optional Feature:
- Macro: IOT_DEBOUNCE_EN.
- Defined:
  - Each device has a saturating counter that counts cycles where dev_on[i] != dev_q[i] and resets to 0 when they match.
  - An edge is recognised only when the counter reaches DEBOUNCE_CYCLES. At that point dev_q[i] updates and the counter clears.
  - Latency becomes DEBOUNCE_CYCLES+1 cycles. Pulses shorter than DEBOUNCE_CYCLES are ignored completely.
  - Counters reset to 0.
- Undefined: no counters; dev_q follows dev_on every cycle as described above.

Test Plan (N_DEV=4, IOT_DEBOUNCE_EN undefined):
1. Reset and reconnect:
   - Hold rst=0 with dev_on=4'b1111 → change=0, on_off=0, dev_id=0, pending_cnt=0.
   - Release rst → change=1, on_off=1 for four consecutive cycles with dev_id 0,1,2,3, then change=0.
2. Single transition:
   - dev_on 0000→0100 → one cycle later a single pulse: change=1, on_off=1, dev_id=2.
   - dev_on 0100→0000 → a single pulse with on_off=0, dev_id=2.
3. Simultaneous edges: dev_on 0000→1011 → pending_cnt 3, 2, 1, 0 on successive cycles; events dev_id 0, 1, 3, all on_off=1.
4. Glitch cancel:
   - dev_on 0000→1111, then dev_on[3]=0 on the next cycle.
   - Required: only ids 0, 1, 2 are issued; no event for id 3; pending_cnt never exceeds 4.
5. Round-robin:
   - After the pulse for dev_id=2 (rr_ptr=3), raise devices 0 and 3 on the same edge.
   - Required order: dev_id=3, then dev_id=0.
6. Reset mid-drain:
   - Assert rst=0 for one cycle while 3 events are pending and dev_on=0111.
   - Required: the next cycle has change=0 and pending_cnt=0. After release, three fresh on events are issued for ids 0, 1, 2.
